rle_run_encoder: RTL

Parametrised run-length encoder for the JPEG encoder's RLE stage. It sits between the zig-zag coefficient stream and the Huffman stage. It counts zero AC runs per block and emits (run, size, amplitude) tokens, with DC passthrough, optional ZRL splitting, and EOB insertion. Valid/ready handshake on both sides, with one registered output slot.

---
 rtl/rle_run_encoder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rle_run_encoder.sv
// rle_run_encoder: zig-zag coefficients in, JPEG (run, size, amplitude) tokens out, with DC passthrough and EOB.
// Define RLE_ZRL_EN to split zero runs of 2^RUN_W or more into ZRL tokens; RUN_W defaults to a full-block run otherwise.
module rle_run_encoder #(
    parameter int COEF_W  = 12,
`ifdef RLE_ZRL_EN
    parameter int RUN_W   = 4,
`else
    parameter int RUN_W   = 6,
`endif
    parameter int SIZE_W  = 4,
    parameter int BLK_LEN = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COEF_W-1:0] in_coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RUN_W-1:0]  out_run,
    output logic [SIZE_W-1:0] out_size,
    output logic [COEF_W-1:0] out_amp,
    output logic              out_dc,
    output logic              out_eob
);
    localparam int IDX_W = $clog2(BLK_LEN);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BLK_LEN - 1);

    typedef struct packed {
        logic [RUN_W-1:0]  run;
        logic [SIZE_W-1:0] size;
        logic [COEF_W-1:0] amp;
        logic              dc;
        logic              eob;
    } tok_t;

    if (SIZE_W < $clog2(COEF_W + 1)) begin : g_size_w_chk
        $error("SIZE_W too narrow for COEF_W");
    end
`ifndef RLE_ZRL_EN
    if (RUN_W < IDX_W) begin : g_run_w_chk
        $error("RUN_W must hold a full-block zero run when ZRL splitting is disabled");
    end
`endif

    // Magnitude is taken as unsigned so the most negative value still reports COEF_W bits.
    function automatic logic [SIZE_W-1:0] coef_size(input logic [COEF_W-1:0] c);
        logic [COEF_W-1:0] mag;
        coef_size = '0;
        mag = c[COEF_W-1] ? -c : c;
        for (int i = 0; i < COEF_W; i++)
            if (mag[i]) coef_size = SIZE_W'(i + 1);
    endfunction

    function automatic tok_t mk_tok(input logic [RUN_W-1:0] run, input logic [COEF_W-1:0] c,
                                    input logic dc, input logic eob);
        mk_tok.run  = run;
        mk_tok.size = coef_size(c);
        mk_tok.amp  = c[COEF_W-1] ? c - COEF_W'(1) : c;
        mk_tok.dc   = dc;
        mk_tok.eob  = eob;
    endfunction

    logic             out_valid_q, out_valid_d;
    tok_t             tok_q, tok_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] zcnt_q, zcnt_d;
    logic             slot_free, accept;
`ifdef RLE_ZRL_EN
    localparam logic [0:0]  ACCEPT = 1'b0;
    localparam logic [0:0]  ZRL    = 1'b1;
    localparam logic [31:0] ZTH    = 32'(2 ** RUN_W);
    logic [0:0]        state_q, state_d;
    logic [COEF_W-1:0] coef_q, coef_d;
    logic [31:0]       zcnt_w;
`endif

    always_comb begin
        slot_free   = !out_valid_q || out_ready;
`ifdef RLE_ZRL_EN
        in_ready    = rst && slot_free && state_q == ACCEPT;
        state_d     = state_q;
        coef_d      = coef_q;
        zcnt_w      = 32'(zcnt_q);
`else
        in_ready    = rst && slot_free;
`endif
        accept      = in_valid && in_ready;
        idx_d       = idx_q;
        zcnt_d      = zcnt_q;
        tok_d       = tok_q;
        out_valid_d = out_valid_q && !out_ready;
        if (accept) begin
            idx_d = (idx_q == LAST) ? '0 : idx_q + IDX_W'(1);
            if (idx_q == '0) begin
                out_valid_d = 1'b1;
                tok_d       = mk_tok('0, in_coef, 1'b1, 1'b0);
                zcnt_d      = '0;
            end else if (in_coef == '0 && idx_q != LAST) begin
                zcnt_d = zcnt_q + IDX_W'(1);
            end else if (in_coef == '0) begin
                out_valid_d = 1'b1;
                tok_d       = mk_tok('0, '0, 1'b0, 1'b1);
                zcnt_d      = '0;
`ifdef RLE_ZRL_EN
            end else if (zcnt_w >= ZTH) begin
                // First ZRL goes out on the accept edge so each ZRL costs exactly one input stall.
                out_valid_d = 1'b1;
                tok_d       = mk_tok('1, '0, 1'b0, 1'b0);
                zcnt_d      = IDX_W'(zcnt_w - ZTH);
                coef_d      = in_coef;
                state_d     = ZRL;
`endif
            end else begin
                out_valid_d = 1'b1;
                tok_d       = mk_tok(RUN_W'(zcnt_q), in_coef, 1'b0, 1'b0);
                zcnt_d      = '0;
            end
`ifdef RLE_ZRL_EN
        end else if (state_q == ZRL && slot_free) begin
            out_valid_d = 1'b1;
            tok_d       = zcnt_w >= ZTH ? mk_tok('1, '0, 1'b0, 1'b0)
                                        : mk_tok(RUN_W'(zcnt_q), coef_q, 1'b0, 1'b0);
            zcnt_d      = zcnt_w >= ZTH ? IDX_W'(zcnt_w - ZTH) : '0;
            state_d     = zcnt_w >= ZTH ? ZRL : ACCEPT;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            tok_q       <= '0;
            idx_q       <= '0;
            zcnt_q      <= '0;
`ifdef RLE_ZRL_EN
            state_q     <= ACCEPT;
            coef_q      <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            tok_q       <= tok_d;
            idx_q       <= idx_d;
            zcnt_q      <= zcnt_d;
`ifdef RLE_ZRL_EN
            state_q     <= state_d;
            coef_q      <= coef_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_run   = tok_q.run;
    assign out_size  = tok_q.size;
    assign out_amp   = tok_q.amp;
    assign out_dc    = tok_q.dc;
    assign out_eob   = tok_q.eob;
endmodule
